// File: rtl/kamus_pkg.sv
// Shared types for the Kamus load/store unit: access widths, controller states
// and the alignment rule used at request acceptance.
package kamus_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_width_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    RESP,
    FAULT
  } lsu_state_t;

  // Natural alignment: the low offset bits covered by the access size must be zero.
  function automatic logic is_misaligned(input mem_width_t width, input logic [2:0] off);
    logic mis;
    mis = 1'b0;
    case (width)
      MEM_H:   mis = off[0];
      MEM_W:   mis = |off[1:0];
      MEM_D:   mis = |off[2:0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/kamus_lsu_align.sv
// Lane logic: byte enables, store data replication and load lane extraction
// with sign/zero extension. Purely combinational.
module kamus_lsu_align
  import kamus_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  mem_width_t                    width_i,
  input  logic                          unsigned_i,
  input  logic [$clog2(XLEN/8)-1:0]     off_i,
  input  logic [XLEN-1:0]               wdata_i,
  input  logic [XLEN-1:0]               rdata_i,
  output logic [XLEN/8-1:0]             be_o,
  output logic [XLEN-1:0]               wdata_o,
  output logic [XLEN-1:0]               rdata_o
);

  localparam int BE_W = XLEN / 8;

  logic [BE_W-1:0] base_mask;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep_mask;
  logic            sign_bit;

  always_comb begin
    base_mask = '1;
    wdata_o   = wdata_i;
    keep_mask = '1;
    sign_bit  = 1'b0;
    shifted   = rdata_i >> {off_i, 3'b000};
    case (width_i)
      MEM_B: begin
        base_mask = BE_W'(1);
        wdata_o   = {BE_W{wdata_i[7:0]}};
        keep_mask = XLEN'(8'hFF);
        sign_bit  = shifted[7];
      end
      MEM_H: begin
        base_mask = BE_W'(3);
        wdata_o   = {(XLEN/16){wdata_i[15:0]}};
        keep_mask = XLEN'(16'hFFFF);
        sign_bit  = shifted[15];
      end
      MEM_W: begin
        base_mask = BE_W'(4'hF);
        wdata_o   = {(XLEN/32){wdata_i[31:0]}};
        keep_mask = XLEN'(32'hFFFF_FFFF);
        sign_bit  = shifted[31];
      end
      default: begin
        base_mask = '1;
        wdata_o   = wdata_i;
        keep_mask = '1;
        sign_bit  = 1'b0;
      end
    endcase
    be_o = base_mask << off_i;
    // Bits above the access size are filled with the sign unless the load is unsigned.
    rdata_o = (shifted & keep_mask) | ({XLEN{sign_bit & ~unsigned_i}} & ~keep_mask);
  end

endmodule

// File: rtl/kamus_lsu_ctrl.sv
// Load/store controller: accepts one core request at a time, checks alignment,
// drives a req/gnt memory port and returns a single-cycle response pulse.
module kamus_lsu_ctrl
  import kamus_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  mem_width_t        req_width_i,
  input  logic              req_unsigned_i,
  input  logic [XLEN-1:0]   req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  output logic              rsp_valid_o,
  output logic [XLEN-1:0]   rsp_rdata_o,
  output logic              rsp_rd_we_o,
  output logic              rsp_err_misaligned_o,
  output logic              rsp_err_bus_o,
  output logic              dmem_req_o,
  input  logic              dmem_gnt_i,
  output logic [XLEN-1:0]   dmem_addr_o,
  output logic              dmem_we_o,
  output logic [XLEN/8-1:0] dmem_be_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  input  logic              dmem_err_i
);

  localparam int OFF_W = $clog2(XLEN/8);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // Handshakes: a core request transfers on a cycle with req_valid_i && req_ready_o;
  // a memory request transfers on a cycle with dmem_req_o && dmem_gnt_i, and the
  // memory side holds no ready of its own for responses (dmem_rvalid_i is a pulse).

  lsu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              uns_q, uns_d;
  mem_width_t        width_q, width_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              bus_err_q, bus_err_d;

  logic [XLEN/8-1:0] lane_be;
  logic [XLEN-1:0]   lane_wdata;
  logic [XLEN-1:0]   lane_rdata;
  logic              req_bad;

  kamus_lsu_align #(
    .XLEN (XLEN)
  ) u_align (
    .width_i    (width_q),
    .unsigned_i (uns_q),
    .off_i      (addr_q[OFF_W-1:0]),
    .wdata_i    (wdata_q),
    .rdata_i    (dmem_rdata_i),
    .be_o       (lane_be),
    .wdata_o    (lane_wdata),
    .rdata_o    (lane_rdata)
  );

  assign req_bad = is_misaligned(req_width_i, req_addr_i[2:0]) ||
                   ((XLEN == 32) && (req_width_i == MEM_D));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    uns_d     = uns_q;
    width_d   = width_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    bus_err_d = bus_err_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_valid_i) begin
          we_d      = req_we_i;
          uns_d     = req_unsigned_i;
          width_d   = req_width_i;
          addr_d    = req_addr_i;
          wdata_d   = req_wdata_i;
          rdata_d   = '0;
          bus_err_d = 1'b0;
          state_d   = req_bad ? FAULT : REQ;
        end
      end
      REQ: begin
        if (dmem_gnt_i) begin
          // Counter reads 0 in the grant cycle and counts cycles since grant.
          cnt_d   = CNT_W'(1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (dmem_rvalid_i) begin
          bus_err_d = dmem_err_i;
          rdata_d   = (!we_q && !dmem_err_i) ? lane_rdata : '0;
          state_d   = RESP;
        end else if (cnt_q >= CNT_W'(TIMEOUT - 1)) begin
          bus_err_d = 1'b1;
          rdata_d   = '0;
          state_d   = RESP;
        end
      end
      RESP:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      width_q   <= MEM_B;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      uns_q     <= uns_d;
      width_q   <= width_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

  // All outputs decode registered state, so nothing combinational reaches from input to output.
  assign req_ready_o          = (state_q == IDLE);
  assign dmem_req_o           = (state_q == REQ);
  assign dmem_addr_o          = dmem_req_o ? {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign dmem_we_o            = dmem_req_o & we_q;
  assign dmem_be_o            = dmem_req_o ? lane_be : '0;
  assign dmem_wdata_o         = dmem_req_o ? lane_wdata : '0;
  assign rsp_valid_o          = (state_q == RESP) || (state_q == FAULT);
  assign rsp_rdata_o          = (state_q == RESP) ? rdata_q : '0;
  assign rsp_rd_we_o          = (state_q == RESP) & ~we_q & ~bus_err_q;
  assign rsp_err_misaligned_o = (state_q == FAULT);
  assign rsp_err_bus_o        = (state_q == RESP) & bus_err_q;

endmodule
